phased_clk_gen: RTL and testbench

//   Multi-channel phased clock generator for the ultrasonic transmit array.

---
 rtl/phased_clk_pkg.sv | 22 ++
 rtl/pclk_channel.sv | 70 +++++++
 rtl/phased_clk_gen.sv | 130 +++++++++++++
 tb/tb_phased_clk_gen.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/phased_clk_pkg.sv
// rtl/phased_clk_pkg.sv - shared types, constants and helpers for the phased clock generator
//
// Purpose : FSM state type, default widths/reset values and the half-period
//           clamp used by phased_clk_gen and pclk_channel.
// Ports   : none (package)
package phased_clk_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ALIGN = 2'd1,
    RUN   = 2'd2
  } state_t;

  localparam int CW_DEF   = 10;
  localparam int HALF_DEF = 875;

  // A programmed half period of 0 would never toggle; run it as 1 (clk/2).
  function automatic int unsigned clamp_half(input int unsigned half);
    return (half == 32'd0) ? 32'd1 : half;
  endfunction

endpackage

// File: rtl/pclk_channel.sv
// rtl/pclk_channel.sv - one output channel: start-delay down-counter plus half-period toggle
//
// Purpose : Holds clk_o low for p cycles after load, then raises it and
//           toggles it every h cycles while run is high.
// Ports   : clk, rst (async, active-low)
//           load     - capture p, hold output low (start edge)
//           run      - count (ALIGN or RUN)
//           clear    - force output low and zero all counters (highest priority)
//           h        - effective half period, already clamped to >= 1
//           p        - start delay, sampled only on load
//           clk_o    - phased square wave
//           released - channel has risen, or rises on this edge
module pclk_channel #(
  parameter int CW = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          run,
  input  logic          clear,
  input  logic [CW-1:0] h,
  input  logic [CW-1:0] p,
  output logic          clk_o,
  output logic          released
);

  logic [CW-1:0] ph_cnt;
  logic [CW-1:0] half_cnt;
  logic          rel_q;

  // Combinational look-ahead so the top can enter RUN on the very edge the
  // last channel rises.
  assign released = rel_q | (ph_cnt == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ph_cnt   <= '0;
      half_cnt <= '0;
      rel_q    <= 1'b0;
      clk_o    <= 1'b0;
    end else if (clear) begin
      ph_cnt   <= '0;
      half_cnt <= '0;
      rel_q    <= 1'b0;
      clk_o    <= 1'b0;
    end else if (load) begin
      ph_cnt   <= p;
      half_cnt <= '0;
      rel_q    <= 1'b0;
      clk_o    <= 1'b0;
    end else if (run) begin
      if (!rel_q) begin
        if (ph_cnt == '0) begin
          rel_q    <= 1'b1;
          clk_o    <= 1'b1;
          half_cnt <= '0;
        end else begin
          ph_cnt <= ph_cnt - 1'b1;
        end
      end else if (half_cnt == (h - 1'b1)) begin
        // Wrap at h-1 so the counter never reaches h and cannot overflow.
        clk_o    <= ~clk_o;
        half_cnt <= '0;
      end else begin
        half_cnt <= half_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/phased_clk_gen.sv
// rtl/phased_clk_gen.sv - multi-channel phased clock generator for the ultrasonic transmit array
//
// Purpose : Common divided square wave on NCH channels, each with its own
//           programmable start delay. Config lands in shadow registers and
//           is copied to the active set on start.
// Ports   : clk, rst (async, active-low)
//           div_we/div_half       - half-period shadow write (0 runs as 1)
//           ph_we/ph_ch/ph_val    - per-channel phase shadow write
//           start/stop            - burst control pulses (stop wins)
//           busy                  - registered, high in ALIGN or RUN
//           cfg_err               - 1-cycle pulse for a dropped write
//           clk_out               - phased square waves
module phased_clk_gen #(
  parameter  int NCH      = 8,
  parameter  int CW       = phased_clk_pkg::CW_DEF,
  parameter  int HALF_DEF = phased_clk_pkg::HALF_DEF,
  localparam int CHW      = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           div_we,
  input  logic [CW-1:0]  div_half,
  input  logic           ph_we,
  input  logic [CHW-1:0] ph_ch,
  input  logic [CW-1:0]  ph_val,
  input  logic           start,
  input  logic           stop,
  output logic           busy,
  output logic           cfg_err,
  output logic [NCH-1:0] clk_out
);

  import phased_clk_pkg::*;

  state_t         state;
  state_t         state_nx;
  logic [CW-1:0]  half_sh;
  logic [CW-1:0]  half_act;
  logic [CW-1:0]  ph_sh  [NCH];
  logic [CW-1:0]  ph_act [NCH];
  logic [CW-1:0]  ch_p   [NCH];
  logic [CW-1:0]  h_eff;
  logic [NCH-1:0] rel;
  logic           ch_load;
  logic           ch_run;
  logic           ch_clear;
  logic           idle;
  logic [CHW:0]   ph_ch_ext;
  logic           ch_ok;
  logic           wr_err;

  assign idle      = (state == IDLE);
  assign ph_ch_ext = {1'b0, ph_ch};
  assign ch_ok     = (ph_ch_ext < (CHW+1)'(NCH));
  assign wr_err    = (div_we && !idle) || (ph_we && (!idle || !ch_ok));
  assign h_eff     = CW'(clamp_half(32'(half_act)));

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  // Next state
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start && !stop) state_nx = ALIGN;
      ALIGN:   if (stop) state_nx = IDLE;
               else if (&rel) state_nx = RUN;
      RUN:     if (stop) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Channel control
  always_comb begin
    ch_load  = idle && start && !stop;
    ch_run   = !idle;
    ch_clear = stop || (idle && !ch_load);
  end

  // Channels load the shadow phase directly on the start edge, since the
  // active copy is only being written on that same edge.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      ch_p[i] = ch_load ? ph_sh[i] : ph_act[i];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) busy <= 1'b0;
    else      busy <= (state_nx != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      half_sh  <= CW'(HALF_DEF);
      half_act <= CW'(HALF_DEF);
      cfg_err  <= 1'b0;
      for (int i = 0; i < NCH; i++) begin
        ph_sh[i]  <= '0;
        ph_act[i] <= '0;
      end
    end else begin
      cfg_err <= wr_err;
      if (div_we && idle)          half_sh     <= div_half;
      if (ph_we && idle && ch_ok)  ph_sh[ph_ch] <= ph_val;
      if (ch_load) begin
        half_act <= half_sh;
        for (int i = 0; i < NCH; i++) ph_act[i] <= ph_sh[i];
      end
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    pclk_channel #(.CW(CW)) u_ch (
      .clk      (clk),
      .rst      (rst),
      .load     (ch_load),
      .run      (ch_run),
      .clear    (ch_clear),
      .h        (h_eff),
      .p        (ch_p[i]),
      .clk_o    (clk_out[i]),
      .released (rel[i])
    );
  end

endmodule

// File: tb/tb_phased_clk_gen.sv
// tb/tb_phased_clk_gen.sv - self-checking bench for phased_clk_gen
module tb_phased_clk_gen;

  localparam int NCH  = 6;
  localparam int CW   = 10;
  localparam int CHW  = 3;
  localparam int HDEF = 875;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           div_we = 1'b0;
  logic [CW-1:0]  div_half = '0;
  logic           ph_we = 1'b0;
  logic [CHW-1:0] ph_ch = '0;
  logic [CW-1:0]  ph_val = '0;
  logic           start = 1'b0;
  logic           stop = 1'b0;
  logic           busy;
  logic           cfg_err;
  logic [NCH-1:0] clk_out;

  int ncomp = 0;
  int nfail = 0;

  // Reference model state
  int sh_half;
  int act_half;
  int sh_ph  [NCH];
  int act_ph [NCH];
  bit mbusy;
  int kcur;

  phased_clk_gen #(.NCH(NCH), .CW(CW), .HALF_DEF(HDEF)) dut (
    .clk(clk), .rst(rst), .div_we(div_we), .div_half(div_half),
    .ph_we(ph_we), .ph_ch(ph_ch), .ph_val(ph_val),
    .start(start), .stop(stop), .busy(busy), .cfg_err(cfg_err), .clk_out(clk_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncomp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Channel i after the k-th edge following the start edge: low until edge 1+p,
  // then high for h edges, low for h edges, and so on.
  function automatic logic [NCH-1:0] exp_vec(input int k);
    logic [NCH-1:0] v;
    int h;
    h = (act_half == 0) ? 1 : act_half;
    v = '0;
    for (int i = 0; i < NCH; i++)
      if (k >= 1 + act_ph[i]) v[i] = (((k - 1 - act_ph[i]) / h) % 2) == 0;
    return v;
  endfunction

  task automatic model_reset();
    sh_half = HDEF; act_half = HDEF; mbusy = 0; kcur = 0;
    for (int i = 0; i < NCH; i++) begin sh_ph[i] = 0; act_ph[i] = 0; end
  endtask

  task automatic check_state(input string tag, input bit err_exp);
    chk({tag, ":clk_out"}, 64'(clk_out), mbusy ? 64'(exp_vec(kcur)) : 64'd0);
    chk({tag, ":busy"}, 64'(busy), 64'(mbusy));
    chk({tag, ":cfg_err"}, 64'(cfg_err), 64'(err_exp));
  endtask

  task automatic cycle(input bit st, input bit sp, input bit dwe, input int dv,
                       input bit pwe, input int pc, input int pv, input string tag);
    bit err;
    @(negedge clk);
    start = st; stop = sp; div_we = dwe; div_half = CW'(dv);
    ph_we = pwe; ph_ch = CHW'(pc); ph_val = CW'(pv);
    @(posedge clk); #1;
    start = 0; stop = 0; div_we = 0; ph_we = 0;
    err = (dwe && mbusy) || (pwe && (mbusy || pc >= NCH));
    if (!mbusy) begin
      if (dwe) sh_half = dv;
      if (pwe && pc < NCH) sh_ph[pc] = pv;
    end
    if (sp) mbusy = 0;
    else if (st && !mbusy) begin
      act_half = sh_half; act_ph = sh_ph; mbusy = 1; kcur = 0;
    end else if (mbusy) kcur++;
    check_state(tag, err);
  endtask

  task automatic tick(input int n, input string tag);
    for (int j = 0; j < n; j++) cycle(0, 0, 0, 0, 0, 0, 0, tag);
  endtask
  task automatic go(input string tag);   cycle(1, 0, 0, 0, 0, 0, 0, tag); endtask
  task automatic halt(input string tag); cycle(0, 1, 0, 0, 0, 0, 0, tag); endtask
  task automatic wr_div(input int v, input string tag); cycle(0, 0, 1, v, 0, 0, 0, tag); endtask
  task automatic wr_ph(input int c, input int v, input string tag); cycle(0, 0, 0, 0, 1, c, v, tag); endtask

  task automatic set_s2();
    int pv [NCH];
    pv = '{0, 2, 5, 9, 3, 7};
    wr_div(4, "s2_div");
    for (int i = 0; i < NCH; i++) wr_ph(i, pv[i], "s2_ph");
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_state("reset", 0);
    @(negedge clk);
    rst = 1;

    // 1. Defaults: rise at T0+1, period 1750
    go("s1_start");
    tick(1760, "s1_run");
    halt("s1_stop");

    // 2. half=4, phases {0,2,5,9,...}
    set_s2();
    go("s2_start");
    tick(40, "s2_run");
    halt("s2_stop");

    // 3. half=0 -> clk/2, half=1023 -> period 2046
    wr_div(0, "s3_div0");
    go("s3a_start");
    tick(20, "s3a_run");
    halt("s3a_stop");
    wr_div(1023, "s3_div1023");
    go("s3b_start");
    tick(4110, "s3b_run");
    halt("s3b_stop");

    // 4. rejected writes, IDLE writes take effect at next start
    wr_div(4, "s4_div");
    go("s4_start");
    tick(5, "s4_run");
    wr_ph(1, 20, "s4_ph_busy");
    wr_div(7, "s4_div_busy");
    cycle(0, 0, 1, 9, 1, 2, 13, "s4_both_busy");
    tick(10, "s4_run2");
    halt("s4_stop");
    wr_ph(6, 3, "s4_ph_ch6");
    wr_ph(7, 3, "s4_ph_ch7");
    cycle(0, 0, 1, 3, 1, 2, 11, "s4_both_idle");
    tick(3, "s4_idle");
    go("s4_restart");
    tick(40, "s4_run3");
    halt("s4_stop2");

    // 5. start+stop together, stop mid-ALIGN and mid-RUN, restart timing
    set_s2();
    cycle(1, 1, 0, 0, 0, 0, 0, "s5_start_stop");
    tick(3, "s5_idle");
    go("s5_start");
    tick(4, "s5_align");
    halt("s5_stop_align");
    go("s5_start2");
    tick(25, "s5_run");
    cycle(1, 0, 0, 0, 0, 0, 0, "s5_start_busy");
    tick(5, "s5_run2");
    halt("s5_stop_run");
    go("s5_restart");
    tick(40, "s5_run3");

    // 6. async reset mid-RUN
    @(negedge clk);
    #2 rst = 0;
    #1;
    model_reset();
    check_state("s6_async", 0);
    @(negedge clk);
    rst = 1;
    go("s6_start");
    tick(900, "s6_run");
    halt("s6_stop");

    // Randomized bursts
    for (int r = 0; r < 10; r++) begin
      wr_div((r == 0) ? 0 : $urandom_range(1, 9), "rnd_div");
      for (int i = 0; i < NCH; i++) wr_ph(i, $urandom_range(0, 25), "rnd_ph");
      go("rnd_start");
      for (int j = $urandom_range(10, 80); j > 0; j--) begin
        case ($urandom_range(0, 15))
          0:       cycle(1, 0, 0, 0, 0, 0, 0, "rnd_start_busy");
          1:       wr_ph($urandom_range(0, 7), $urandom_range(0, 1023), "rnd_ph_busy");
          default: tick(1, "rnd_run");
        endcase
      end
      halt("rnd_stop");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
    $finish;
  end

endmodule
